mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port synchronous `mem` block (one access per clock, registered read data one cycle after the access) between port 0 (instruction fetch) and port 1 (load/store). Uses valid/ready request handshakes with round-robin arbitration. Drives `mem` address, write data, and enables for the winning request. Returns a response, with read data or a write acknowledge, on the winning port exactly one cycle later.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/rr_arb2.sv | 22 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// A port select is a single bit: 0 = instruction fetch, 1 = load/store.
package mem_arb_pkg;

   typedef logic port_t;

   localparam port_t PORT0 = 1'b0;
   localparam port_t PORT1 = 1'b1;

   localparam int DEFAULT_MEM_SIZE = 256;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, and on a tie the port
// that did not win last time wins. Purely combinational, one-hot output.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_t      last,
   output logic [1:0] grant
);

   // one-hot grant selection
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last == PORT0) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port synchronous memory between instruction fetch (port 0)
// and load/store (port 1); each accepted request gets a response one cycle later.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_req_we,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_rsp_valid,
   output logic [DATA_W-1:0] p0_rsp_rdata,
   output logic              p0_rsp_err,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_req_we,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] p1_rsp_rdata,
   output logic              p1_rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rd_data
);

   // One extra bit so the limit is representable even when MEM_SIZE == 2**ADDR_W.
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

   logic [1:0]        req_s;
   logic [1:0]        grant_s;
   logic              accept_s;
   port_t             win_s;
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              in_range_s;
   logic              rsp_live_s;
   logic [DATA_W-1:0] rd_data_s;

   port_t             last_grant_r;
   port_t             rsp_port_r;
   logic              rsp_valid_r;
   logic              rsp_err_r;
   logic              rsp_read_r;

   assign req_s = rst ? 2'b00 : {p1_req_valid, p0_req_valid};

   rr_arb2 u_rr_arb2 (
      .req   (req_s),
      .last  (last_grant_r),
      .grant (grant_s)
   );

   assign p0_req_ready = grant_s[0];
   assign p1_req_ready = grant_s[1];
   assign accept_s     = grant_s[0] | grant_s[1];
   assign win_s        = grant_s[1] ? PORT1 : PORT0;

   // winner payload mux and memory command; out-of-range accepts leave mem idle
   always_comb begin
      sel_we_s    = p0_req_we;
      sel_addr_s  = p0_req_addr;
      sel_wdata_s = p0_req_wdata;
      if (win_s == PORT1) begin
         sel_we_s    = p1_req_we;
         sel_addr_s  = p1_req_addr;
         sel_wdata_s = p1_req_wdata;
      end else begin
         sel_we_s    = p0_req_we;
         sel_addr_s  = p0_req_addr;
         sel_wdata_s = p0_req_wdata;
      end
      in_range_s  = ({1'b0, sel_addr_s} < MEM_LIMIT);
      mem_addr    = {ADDR_W{1'b0}};
      mem_wr_data = {DATA_W{1'b0}};
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      if (accept_s && in_range_s) begin
         mem_addr    = sel_addr_s;
         mem_wr_data = sel_wdata_s;
         mem_we      = sel_we_s;
         mem_re      = !sel_we_s;
      end else begin
         mem_addr    = {ADDR_W{1'b0}};
         mem_wr_data = {DATA_W{1'b0}};
         mem_we      = 1'b0;
         mem_re      = 1'b0;
      end
   end

   // arbitration history and response bookkeeping for the following cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_r <= PORT1;
         rsp_port_r   <= PORT0;
         rsp_valid_r  <= 1'b0;
         rsp_err_r    <= 1'b0;
         rsp_read_r   <= 1'b0;
      end else begin
         rsp_valid_r <= accept_s;
         if (accept_s) begin
            last_grant_r <= win_s;
            rsp_port_r   <= win_s;
            rsp_err_r    <= !in_range_s;
            rsp_read_r   <= !sel_we_s;
         end else begin
            rsp_err_r  <= 1'b0;
            rsp_read_r <= 1'b0;
         end
      end
   end

   // Read data arrives from mem in the response cycle, so it is steered here
   // rather than registered; a reset in that cycle suppresses the response.
   assign rsp_live_s = rsp_valid_r & ~rst;
   assign rd_data_s  = (rsp_live_s && rsp_read_r && !rsp_err_r) ? mem_rd_data : {DATA_W{1'b0}};

   assign p0_rsp_valid = rsp_live_s && (rsp_port_r == PORT0);
   assign p0_rsp_rdata = p0_rsp_valid ? rd_data_s : {DATA_W{1'b0}};
   assign p0_rsp_err   = p0_rsp_valid && rsp_err_r;

   assign p1_rsp_valid = rsp_live_s && (rsp_port_r == PORT1);
   assign p1_rsp_rdata = p1_rsp_valid ? rd_data_s : {DATA_W{1'b0}};
   assign p1_rsp_err   = p1_rsp_valid && rsp_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        p0_req_valid, p0_req_ready, p0_req_we;
   logic [31:0] p0_req_addr, p0_req_wdata;
   logic        p0_rsp_valid, p0_rsp_err;
   logic [31:0] p0_rsp_rdata;
   logic        p1_req_valid, p1_req_ready, p1_req_we;
   logic [31:0] p1_req_addr, p1_req_wdata;
   logic        p1_rsp_valid, p1_rsp_err;
   logic [31:0] p1_rsp_rdata;
   logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
   logic        mem_we, mem_re;

   int n_checks = 0;
   int n_pass   = 0;

   // attached memory block and the model's independent copy of it
   logic [31:0] mem_arr [0:255];
   logic [31:0] ref_mem [0:255];

   // model state
   int          m_last;
   bit          pend_v;
   int          pend_port;
   logic [31:0] pend_rdata;
   bit          pend_err;

   mem_arbiter #(.MEM_SIZE(256), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rd_data(mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wr_data;
      if (mem_re) mem_rd_data <= mem_arr[mem_addr[7:0]];
   end

   // Round-robin rule: lone requester wins, a tie goes to the port that did not win last.
   function automatic int exp_grant();
      if (rst) return -1;
      if (p0_req_valid && p1_req_valid) return (m_last == 0) ? 1 : 0;
      if (p0_req_valid) return 0;
      if (p1_req_valid) return 1;
      return -1;
   endfunction

   // advance one clock and update the model with whatever was accepted
   task automatic tick();
      int g;
      logic we;
      logic [31:0] a, d;
      g  = exp_grant();
      we = (g == 1) ? p1_req_we    : p0_req_we;
      a  = (g == 1) ? p1_req_addr  : p0_req_addr;
      d  = (g == 1) ? p1_req_wdata : p0_req_wdata;
      @(posedge clk);
      if (rst) begin
         pend_v = 0;
         m_last = 1;
      end else if (g >= 0) begin
         pend_v    = 1;
         pend_port = g;
         m_last    = g;
         if (a >= 32'd256) begin
            pend_err   = 1;
            pend_rdata = 32'd0;
         end else begin
            pend_err   = 0;
            pend_rdata = we ? 32'd0 : ref_mem[a[7:0]];
            if (we) ref_mem[a[7:0]] = d;
         end
      end else begin
         pend_v = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'd7; p0_req_wdata = 32'h1234;
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'd8; p1_req_wdata = 32'h0;
      @(negedge clk);
      n_checks++;
      if ({p0_req_ready, p1_req_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {p0_req_ready, p1_req_ready});
      else n_pass++;
      n_checks++;
      if ({mem_we, mem_re} !== 2'b00) $display("FAIL reset_mem_en: got %b expected 00", {mem_we, mem_re});
      else n_pass++;
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err} !== 4'b0000)
         $display("FAIL reset_rsp: got %b expected 0000", {p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err});
      else n_pass++;
      n_checks++;
      if ((p0_rsp_rdata | p1_rsp_rdata) !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", p0_rsp_rdata | p1_rsp_rdata);
      else n_pass++;
      rst = 1'b0;
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'd5; p0_req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if ({p0_req_ready, mem_we, mem_re} !== 3'b110) $display("FAIL wr_issue: got %b expected 110", {p0_req_ready, mem_we, mem_re});
      else n_pass++;
      n_checks++;
      if (mem_addr !== 32'd5 || mem_wr_data !== 32'hDEADBEEF) $display("FAIL wr_payload: got %h/%h expected 5/deadbeef", mem_addr, mem_wr_data);
      else n_pass++;
      tick();
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'd5; p1_req_wdata = 32'h0;
      @(negedge clk);
      n_checks++;
      if ({p0_rsp_valid, p0_rsp_err} !== 2'b10 || p0_rsp_rdata !== 32'd0)
         $display("FAIL wr_ack: got v/e %b rdata %h expected 10 / 0", {p0_rsp_valid, p0_rsp_err}, p0_rsp_rdata);
      else n_pass++;
      n_checks++;
      if ({p1_req_ready, mem_re} !== 2'b11) $display("FAIL rd_issue: got %b expected 11", {p1_req_ready, mem_re});
      else n_pass++;
      tick();
      p1_req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({p1_rsp_valid, p0_rsp_valid} !== 2'b10 || p1_rsp_rdata !== 32'hDEADBEEF)
         $display("FAIL rd_after_wr: got v %b rdata %h expected 10 / deadbeef", {p1_rsp_valid, p0_rsp_valid}, p1_rsp_rdata);
      else n_pass++;
      tick();
   endtask

   task automatic test_contention();
      int g;
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'd1; p0_req_wdata = 32'h0;
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'd2; p1_req_wdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         if (c == 4) begin
            p0_req_valid = 1'b0;
            p1_req_valid = 1'b0;
         end
         @(negedge clk);
         g = exp_grant();
         n_checks++;
         if ({p1_req_ready, p0_req_ready} !== {g == 1, g == 0})
            $display("FAIL contention_grant c%0d: got %b expected %b", c, {p1_req_ready, p0_req_ready}, {g == 1, g == 0});
         else n_pass++;
         if (c > 0) begin
            n_checks++;
            if ({p1_rsp_valid, p0_rsp_valid} !== {pend_port == 1, pend_port == 0} ||
                (pend_port == 1 ? p1_rsp_rdata : p0_rsp_rdata) !== pend_rdata)
               $display("FAIL contention_rsp c%0d: got v %b rdata %h expected port %0d rdata %h",
                        c, {p1_rsp_valid, p0_rsp_valid}, (pend_port == 1 ? p1_rsp_rdata : p0_rsp_rdata), pend_port, pend_rdata);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_out_of_range();
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'd256; p1_req_wdata = 32'h0;
      @(negedge clk);
      n_checks++;
      if ({p1_req_ready, mem_we, mem_re} !== 3'b100) $display("FAIL oor_issue: got %b expected 100", {p1_req_ready, mem_we, mem_re});
      else n_pass++;
      tick();
      p1_req_valid = 1'b0;
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'h8000_0005; p0_req_wdata = 32'h5555_AAAA;
      @(negedge clk);
      n_checks++;
      if ({p1_rsp_valid, p1_rsp_err} !== 2'b11 || p1_rsp_rdata !== 32'd0)
         $display("FAIL oor_rsp: got v/e %b rdata %h expected 11 / 0", {p1_rsp_valid, p1_rsp_err}, p1_rsp_rdata);
      else n_pass++;
      n_checks++;
      if ({p0_req_ready, mem_we, mem_re} !== 3'b100) $display("FAIL oor_hibit_issue: got %b expected 100", {p0_req_ready, mem_we, mem_re});
      else n_pass++;
      tick();
      p0_req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({p0_rsp_valid, p0_rsp_err} !== 2'b11) $display("FAIL oor_hibit_rsp: got %b expected 11", {p0_rsp_valid, p0_rsp_err});
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_midop();
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'd3; p0_req_wdata = 32'h0;
      @(negedge clk);
      n_checks++;
      if (p0_req_ready !== 1'b1) $display("FAIL midrst_accept: got %b expected 1", p0_req_ready);
      else n_pass++;
      tick();
      rst = 1'b1;
      p0_req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) $display("FAIL midrst_drop_t1: got %b expected 00", {p0_rsp_valid, p1_rsp_valid});
      else n_pass++;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) $display("FAIL midrst_drop_t2: got %b expected 00", {p0_rsp_valid, p1_rsp_valid});
      else n_pass++;
      tick();
      p0_req_valid = 1'b1;
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'd4;
      @(negedge clk);
      n_checks++;
      if ({p1_req_ready, p0_req_ready} !== 2'b01) $display("FAIL midrst_first_tie: got %b expected 01", {p1_req_ready, p0_req_ready});
      else n_pass++;
      tick();
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int g;
      bit hold0, hold1, inr, we;
      logic [31:0] a, d, e_addr, e_wdata;
      hold0 = 0;
      hold1 = 0;
      for (int c = 0; c < 400; c++) begin
         if (!hold0) begin
            p0_req_valid = ($urandom_range(0, 3) != 0);
            p0_req_we    = 1'($urandom_range(0, 1));
            p0_req_addr  = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 255);
            p0_req_wdata = $urandom;
         end
         if (!hold1) begin
            p1_req_valid = ($urandom_range(0, 3) != 0);
            p1_req_we    = 1'($urandom_range(0, 1));
            p1_req_addr  = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 255);
            p1_req_wdata = $urandom;
         end
         @(negedge clk);
         g   = exp_grant();
         we  = (g == 1) ? p1_req_we    : p0_req_we;
         a   = (g == 1) ? p1_req_addr  : p0_req_addr;
         d   = (g == 1) ? p1_req_wdata : p0_req_wdata;
         inr = (g >= 0) && (a < 32'd256);
         e_addr  = inr ? a : 32'd0;
         e_wdata = inr ? d : 32'd0;
         n_checks++;
         if ({p1_req_ready, p0_req_ready} !== {g == 1, g == 0})
            $display("FAIL rnd_grant c%0d: got %b expected %b", c, {p1_req_ready, p0_req_ready}, {g == 1, g == 0});
         else n_pass++;
         n_checks++;
         if ({mem_we, mem_re} !== {inr && we, inr && !we} || mem_addr !== e_addr || mem_wr_data !== e_wdata)
            $display("FAIL rnd_mem c%0d: got we/re %b addr %h wd %h expected %b %h %h",
                     c, {mem_we, mem_re}, mem_addr, mem_wr_data, {inr && we, inr && !we}, e_addr, e_wdata);
         else n_pass++;
         n_checks++;
         if ({p1_rsp_valid, p0_rsp_valid} !== {pend_v && pend_port == 1, pend_v && pend_port == 0} ||
             {p1_rsp_err, p0_rsp_err} !== {pend_v && pend_err && pend_port == 1, pend_v && pend_err && pend_port == 0} ||
             p0_rsp_rdata !== ((pend_v && pend_port == 0) ? pend_rdata : 32'd0) ||
             p1_rsp_rdata !== ((pend_v && pend_port == 1) ? pend_rdata : 32'd0))
            $display("FAIL rnd_rsp c%0d: got v %b e %b rd %h/%h expected pend %0d port %0d err %0d rd %h",
                     c, {p1_rsp_valid, p0_rsp_valid}, {p1_rsp_err, p0_rsp_err}, p0_rsp_rdata, p1_rsp_rdata,
                     pend_v, pend_port, pend_err, pend_rdata);
         else n_pass++;
         tick();
         hold0 = p0_req_valid && (g != 0);
         hold1 = p1_req_valid && (g != 1);
      end
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] v;
      rst = 1'b1;
      p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = 32'd0; p0_req_wdata = 32'd0;
      p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = 32'd0; p1_req_wdata = 32'd0;
      mem_rd_data = 32'd0;
      m_last = 1; pend_v = 0; pend_port = 0; pend_rdata = 32'd0; pend_err = 0;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         mem_arr[i] = v;
         ref_mem[i] = v;
      end
      #1;
      test_reset();
      test_write_read();
      test_contention();
      test_out_of_range();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
